// File: rtl/dac_seq_pkg.sv
// Shared types and helpers for the DAC channel sequencer.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } seq_state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;

    // Upper bounds for the generic slicing helper below.
    localparam int MAX_WIDTH = 32;
    localparam int MAX_BUS   = 1024;

    function automatic logic [MAX_WIDTH-1:0] ch_code(
        input logic [MAX_BUS-1:0] bus,
        input int unsigned        c,
        input int unsigned        width
    );
        ch_code = MAX_WIDTH'(bus >> (c * width));
    endfunction

endpackage

// File: rtl/dac_ch_sequencer_rr_arbiter.sv
// Combinational round-robin search: first requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);

    int j;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any_req && req[IW'(j)]) begin
                any_req = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dac_ch_sequencer.sv
// Shares one DAC between NUM_CH requesters: round-robin grant, load code, settle, strobe S/H.
module dac_ch_sequencer
    import dac_seq_pkg::*;
#(
    parameter  int               WIDTH         = DEF_WIDTH,
    parameter  int               NUM_CH        = DEF_NUM_CH,
    parameter  int               SETTLE_CYCLES = 16,
    parameter  int               HOLD_CYCLES   = 2,
    parameter  logic [WIDTH-1:0] PARK_CODE     = '0,
    localparam int               CW            = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    // Handshake: channel c's request is consumed on the rising edge where req_valid[c]
    // and req_ready[c] are both high; req_valid must stay high (code stable) until then.
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*WIDTH-1:0] req_code,
    output logic [NUM_CH-1:0]       req_ready,
    output logic [WIDTH-1:0]        dac_code,
    output logic [NUM_CH-1:0]       sh_strobe,
    output logic [CW-1:0]           cur_ch,
    output logic                    busy,
    output seq_state_e              dbg_state
);

    localparam int               SW          = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int               HW          = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LOAD   = HW'(HOLD_CYCLES - 1);

    seq_state_e       state;
    logic [CW-1:0]    rr_ptr;
    logic [SW-1:0]    settle_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [CW-1:0]    gnt_idx;
    logic             any_req;
    logic [WIDTH-1:0] grant_code;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign grant_code = WIDTH'(ch_code(MAX_BUS'(req_code), 32'(cur_ch), WIDTH));
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dac_code   <= PARK_CODE;
            req_ready  <= '0;
            sh_strobe  <= '0;
            busy       <= 1'b0;
            cur_ch     <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_ch    <= gnt_idx;
                        req_ready <= NUM_CH'(1) << gnt_idx;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    req_ready <= '0;
                    if (!req_valid[cur_ch]) begin
                        // Requester withdrew before acceptance: drop it, keep pointer and code.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        dac_code <= grant_code;
                        if ((grant_code != dac_code) && (SETTLE_CYCLES > 0)) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end else begin
                            sh_strobe <= NUM_CH'(1) << cur_ch;
                            hold_cnt  <= HOLD_LOAD;
                            state     <= HOLD;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        sh_strobe <= NUM_CH'(1) << cur_ch;
                        hold_cnt  <= HOLD_LOAD;
                        state     <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        sh_strobe <= '0;
                        busy      <= 1'b0;
                        rr_ptr    <= (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_ch_sequencer.sv
// Bench for dac_ch_sequencer: directed table and sequences plus randomized traffic
// against a transaction-timing model, on a default build and a no-settle/1-cycle-hold build.
module tb_dac_ch_sequencer;
    import dac_seq_pkg::*;

    localparam int S_A = 16;
    localparam int H_A = 2;
    localparam int S_B = 0;
    localparam int H_B = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  vld [2];
    logic [31:0] cod [2];

    logic [3:0] a_rdy, b_rdy, a_stb, b_stb;
    logic [7:0] a_dac, b_dac;
    logic       a_busy, b_busy;
    logic [1:0] a_ch, b_ch;
    seq_state_e a_st, b_st;

    dac_ch_sequencer #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(S_A), .HOLD_CYCLES(H_A),
                       .PARK_CODE(8'h00)) dut_a (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_code(cod[0]), .req_ready(a_rdy),
        .dac_code(a_dac), .sh_strobe(a_stb), .cur_ch(a_ch), .busy(a_busy), .dbg_state(a_st)
    );

    dac_ch_sequencer #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(S_B), .HOLD_CYCLES(H_B),
                       .PARK_CODE(8'h00)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_code(cod[1]), .req_ready(b_rdy),
        .dac_code(b_dac), .sh_strobe(b_stb), .cur_ch(b_ch), .busy(b_busy), .dbg_state(b_st)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is timed by k = cycles since the grant: ready at k=1, code at k=2,
    // strobe for H cycles starting at k=2+settle, idle once k reaches 2+settle+H.
    bit         m_act [2];
    int         m_k   [2];
    int         m_se  [2];
    int         m_ch  [2];
    int         m_ptr [2];
    logic [7:0] m_dac [2];

    function automatic int s_of(input int i); return (i == 0) ? S_A : S_B; endfunction
    function automatic int h_of(input int i); return (i == 0) ? H_A : H_B; endfunction

    task automatic model_reset(input int i);
        m_act[i] = 1'b0; m_k[i] = 0; m_se[i] = 0; m_ch[i] = 0; m_ptr[i] = 0; m_dac[i] = 8'h00;
    endtask

    task automatic model_step(input int i, input logic [3:0] v, input logic [31:0] code);
        logic [7:0] nc;
        bit found;
        if (!m_act[i]) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (!found && v[(m_ptr[i] + j) % 4]) begin
                    found = 1'b1;
                    m_ch[i] = (m_ptr[i] + j) % 4;
                end
            end
            if (found) begin m_act[i] = 1'b1; m_k[i] = 1; end
        end else if (m_k[i] == 1) begin
            if (!v[m_ch[i]]) begin
                m_act[i] = 1'b0;
            end else begin
                nc = code[m_ch[i]*8 +: 8];
                m_se[i] = (nc != m_dac[i] && s_of(i) > 0) ? s_of(i) : 0;
                m_dac[i] = nc;
                m_k[i] = 2;
            end
        end else begin
            m_k[i]++;
            if (m_k[i] == 2 + m_se[i] + h_of(i)) begin
                m_act[i] = 1'b0;
                m_ptr[i] = (m_ch[i] + 1) % 4;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, vld[0], cod[0]);
            model_step(1, vld[1], cod[1]);
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] prev_dac [2];
    logic [3:0] prev_stb [2];
    logic [1:0] got_q [$];
    logic [1:0] exp_q [$];

    task automatic compare(input int i, input logic [3:0] rdy, input logic [3:0] stb,
                           input logic [7:0] dac, input logic busy, input logic [1:0] ch,
                           input seq_state_e st);
        string p;
        logic [3:0] er, es;
        p  = (i == 0) ? "a" : "b";
        er = (m_act[i] && m_k[i] == 1) ? 4'(1 << m_ch[i]) : 4'h0;
        es = (m_act[i] && m_k[i] >= 2 + m_se[i]) ? 4'(1 << m_ch[i]) : 4'h0;
        chk({p, ".ready"}, 32'(rdy), 32'(er));
        chk({p, ".strobe"}, 32'(stb), 32'(es));
        chk({p, ".dac_code"}, 32'(dac), 32'(m_dac[i]));
        chk({p, ".busy"}, 32'(busy), 32'(m_act[i]));
        chk({p, ".cur_ch"}, 32'(ch), 32'(m_ch[i]));
        chk({p, ".onehot"}, 32'($onehot0(rdy) && $onehot0(stb)), 32'd1);
        chk({p, ".state_busy"}, 32'(busy), 32'(st != IDLE));
        if (prev_stb[i] != 4'h0 && stb != 4'h0) chk({p, ".dac_stable"}, 32'(dac), 32'(prev_dac[i]));
        prev_stb[i] = stb;
        prev_dac[i] = dac;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare(0, a_rdy, a_stb, a_dac, a_busy, a_ch, a_st);
            compare(1, b_rdy, b_stb, b_dac, b_busy, b_ch, b_st);
            for (int c = 0; c < 4; c++) if (a_rdy[c]) got_q.push_back(2'(c));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld[0] = 4'h0; vld[1] = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          cyc;
        logic [3:0]  valid;
        logic [31:0] code;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_dac;
        logic [3:0]  exp_strobe;
        logic        exp_busy;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t tbl [7];
    logic [3:0] prev_rdy [2];
    int n;

    initial begin
        vld[0] = 4'h0; vld[1] = 4'h0; cod[0] = '0; cod[1] = '0;
        prev_dac[0] = '0; prev_dac[1] = '0; prev_stb[0] = '0; prev_stb[1] = '0;

        // single ch0 transaction, default build
        tbl[0] = '{0,  4'b0001, 32'h80, 4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{1,  4'b0001, 32'h80, 4'b0001, 8'h00, 4'b0000, 1'b1, 2'd0};
        tbl[2] = '{2,  4'b0000, 32'h80, 4'b0000, 8'h80, 4'b0000, 1'b1, 2'd0};
        tbl[3] = '{17, 4'b0000, 32'h80, 4'b0000, 8'h80, 4'b0000, 1'b1, 2'd0};
        tbl[4] = '{18, 4'b0000, 32'h80, 4'b0000, 8'h80, 4'b0001, 1'b1, 2'd0};
        tbl[5] = '{19, 4'b0000, 32'h80, 4'b0000, 8'h80, 4'b0001, 1'b1, 2'd0};
        tbl[6] = '{20, 4'b0000, 32'h80, 4'b0000, 8'h80, 4'b0000, 1'b0, 2'd0};

        do_reset();
        chk_en = 1'b1;
        n = 0;
        for (int r = 0; r < 7; r++) begin
            while (n < tbl[r].cyc) begin tick(); n++; end
            chk("t1.ready", 32'(a_rdy), 32'(tbl[r].exp_ready));
            chk("t1.dac_code", 32'(a_dac), 32'(tbl[r].exp_dac));
            chk("t1.strobe", 32'(a_stb), 32'(tbl[r].exp_strobe));
            chk("t1.busy", 32'(a_busy), 32'(tbl[r].exp_busy));
            chk("t1.cur_ch", 32'(a_ch), 32'(tbl[r].exp_ch));
            vld[0] = tbl[r].valid;
            cod[0] = tbl[r].code;
        end

        // all four valids held: grant order 0,1,2,3,0
        do_reset();
        got_q.delete();
        cod[0] = 32'h44332211;
        vld[0] = 4'b1111;
        for (int k = 0; k < 300 && got_q.size() < 5; k++) tick();
        chk("t2.grant_count", 32'(got_q.size() >= 5), 32'd1);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        while (exp_q.size() > 0 && got_q.size() > 0) chk("t2.grant_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        vld[0] = 4'h0;

        // ch2 repeats the same code: second transaction skips settling
        do_reset();
        vld[0] = 4'b0100; cod[0] = 32'h0033_0000;
        tick(); chk("t3.ready1", 32'(a_rdy), 32'h4);
        tick(); chk("t3.dac1", 32'(a_dac), 32'h33); vld[0] = 4'h0;
        repeat (18) tick();
        chk("t3.idle1", 32'(a_busy), 32'd0);
        vld[0] = 4'b0100;
        tick(); chk("t3.ready2", 32'(a_rdy), 32'h4);
        tick(); chk("t3.strobe_a", 32'(a_stb), 32'h4); chk("t3.dac2", 32'(a_dac), 32'h33); vld[0] = 4'h0;
        tick(); chk("t3.strobe_b", 32'(a_stb), 32'h4);
        tick(); chk("t3.strobe_end", 32'(a_stb), 32'h0); chk("t3.idle2", 32'(a_busy), 32'd0);

        // ch1 withdraws during its grant; pointer must not move
        do_reset();
        vld[0] = 4'b0010; cod[0] = 32'h6600_5500;
        tick(); chk("t4.ready", 32'(a_rdy), 32'h2); vld[0] = 4'h0;
        tick();
        chk("t4.busy", 32'(a_busy), 32'd0);
        chk("t4.strobe", 32'(a_stb), 32'h0);
        chk("t4.dac_code", 32'(a_dac), 32'h00);
        vld[0] = 4'b1010;
        tick(); chk("t4.regrant", 32'(a_rdy), 32'h2); chk("t4.cur_ch", 32'(a_ch), 32'd1);
        tick(); chk("t4.dac_new", 32'(a_dac), 32'h55); vld[0] = 4'h0;

        // reset during ch3 settle, then ch3 served from scratch
        do_reset();
        vld[0] = 4'b1000; cod[0] = 32'h7700_0000;
        tick(); chk("t5.ready", 32'(a_rdy), 32'h8);
        tick(); chk("t5.dac", 32'(a_dac), 32'h77); vld[0] = 4'h0;
        repeat (3) tick();
        chk("t5.busy_settle", 32'(a_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5.rst_dac", 32'(a_dac), 32'h00);
        chk("t5.rst_strobe", 32'(a_stb), 32'h0);
        chk("t5.rst_busy", 32'(a_busy), 32'd0);
        tick(); rst = 1'b0;
        vld[0] = 4'b1000;
        tick(); chk("t5.ready2", 32'(a_rdy), 32'h8); chk("t5.cur_ch", 32'(a_ch), 32'd3);
        tick(); chk("t5.dac2", 32'(a_dac), 32'h77); vld[0] = 4'h0;
        repeat (15) tick(); chk("t5.no_early_strobe", 32'(a_stb), 32'h0);
        tick(); chk("t5.strobe_a", 32'(a_stb), 32'h8);
        tick(); chk("t5.strobe_b", 32'(a_stb), 32'h8);
        tick(); chk("t5.idle", 32'(a_busy), 32'd0);

        // randomized traffic on both builds, protocol-compliant producers
        do_reset();
        prev_rdy[0] = '0; prev_rdy[1] = '0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (k == 1500) begin
                do_reset();
                prev_rdy[0] = '0; prev_rdy[1] = '0;
            end
            for (int i = 0; i < 2; i++) begin
                logic [3:0] r;
                r = (i == 0) ? a_rdy : b_rdy;
                for (int c = 0; c < 4; c++) begin
                    if (prev_rdy[i][c]) vld[i][c] = 1'b0;
                    if (!vld[i][c] && $urandom_range(0, 5) == 0) begin
                        vld[i][c] = 1'b1;
                        cod[i][c*8 +: 8] = 8'($urandom_range(0, 3) * 85);
                    end
                end
                prev_rdy[i] = r;
            end
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
